// File: rtl/i2s_mic_array_rx.sv
// i2s_mic_array_rx: master-mode I2S receiver; drives shared BCLK/WS and deserialises one left-slot word per mic per frame.
// Latency: word visible (BCLK_DIV*SAMPLE_BITS + BCLK_DIV/2 + 3) clk_in cycles after frame start (787 at 32/24).
// Backpressure: none by default (1-cycle valid pulse, ready_in ignored); `define I2S_RX_HANDSHAKE_EN for held valid + sticky overrun.
module i2s_mic_array_rx #(
  parameter int NUM_MICS      = 3,
  parameter int BCLK_DIV      = 32,   // even, >= 8
  parameter int SLOT_BITS     = 32,
  parameter int SAMPLE_BITS   = 24,   // 2 .. SLOT_BITS-1
  parameter int WARMUP_FRAMES = 4096  // >= 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            en_in,
  input  logic [NUM_MICS-1:0]             mic_data_in,
  output logic                            i2s_bclk_out,
  output logic                            i2s_ws_out,
  output logic [NUM_MICS*SAMPLE_BITS-1:0] sample_out,
  output logic                            sample_valid_out,
  input  logic                            ready_in,
  output logic                            overrun_out
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int BIT_W  = $clog2(2 * SLOT_BITS);
  localparam int WARM_W = $clog2(WARMUP_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(BCLK_DIV / 2);
  // BCLK rises at DIV_HALF; two synchroniser stages later the sampled bit is stable.
  localparam logic [DIV_W-1:0]  DIV_CAP    = DIV_W'(BCLK_DIV / 2 + 2);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_SLOT   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0]  BIT_SAMPLE = BIT_W'(SAMPLE_BITS);
  localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(WARMUP_FRAMES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WARMUP = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;

  logic [1:0]                     state;
  logic [DIV_W-1:0]               div_cnt;
  logic [DIV_W-1:0]               div_nxt;
  logic [BIT_W-1:0]               bit_cnt;
  logic [BIT_W-1:0]               bit_nxt;
  logic [WARM_W-1:0]              warm_cnt;
  logic [NUM_MICS-1:0]            sync1;
  logic [NUM_MICS-1:0]            sync2;
  logic [NUM_MICS*SAMPLE_BITS-1:0] shift_reg;
  logic [NUM_MICS*SAMPLE_BITS-1:0] shift_nxt;
  logic                           active;
  logic                           div_wrap;
  logic                           frame_end;
  logic                           cap_en;
  logic                           word_done;
  logic                           deliver;

  // Counter next-state: both counters pinned at 0 outside WARMUP/RUN,
  // bit_cnt steps on the div_cnt wrap, which is the BCLK falling edge.
  always_comb begin
    active    = (state != IDLE);
    div_wrap  = active && (div_cnt == DIV_LAST);
    frame_end = div_wrap && (bit_cnt == BIT_LAST);
    if (!active || div_wrap) begin
      div_nxt = '0;
    end else begin
      div_nxt = div_cnt + 1'b1;
    end
    if (!active || frame_end) begin
      bit_nxt = '0;
    end else if (div_wrap) begin
      bit_nxt = bit_cnt + 1'b1;
    end else begin
      bit_nxt = bit_cnt;
    end
  end

  // Capture window: left slot bits 1..SAMPLE_BITS (MSB one BCLK after WS falls).
  always_comb begin
    cap_en    = active && (div_cnt == DIV_CAP) && (bit_cnt != '0) && (bit_cnt <= BIT_SAMPLE);
    word_done = cap_en && (bit_cnt == BIT_SAMPLE);
    deliver   = word_done && (state == RUN);
    shift_nxt = shift_reg;
    for (int k = 0; k < NUM_MICS; k++) begin
      shift_nxt[k*SAMPLE_BITS +: SAMPLE_BITS] =
        {shift_reg[k*SAMPLE_BITS +: SAMPLE_BITS-1], sync2[k]};
    end
  end

  // Run-state FSM: stop/restart decisions are only taken at the frame wrap so
  // the mics always see whole frames; a re-assert before the wrap is seamless.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en_in) state <= WARMUP;
        end
        WARMUP: begin
          if (frame_end) begin
            if (!en_in) begin
              state <= IDLE;
            end else if (warm_cnt == WARM_LAST) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (frame_end && !en_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Warm-up frame counter; cleared whenever the receiver is idle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      warm_cnt <= '0;
    end else if (state == IDLE) begin
      warm_cnt <= '0;
    end else if ((state == WARMUP) && frame_end) begin
      warm_cnt <= en_in ? warm_cnt + 1'b1 : '0;
    end
  end

  // Divider and bit counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // BCLK/WS registered from next-state counts so the pins match the counters
  // in the same cycle; WS therefore only moves when BCLK falls.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      i2s_bclk_out <= 1'b0;
      i2s_ws_out   <= 1'b0;
    end else begin
      i2s_bclk_out <= (div_nxt >= DIV_HALF);
      i2s_ws_out   <= (bit_nxt >= BIT_SLOT);
    end
  end

  // Two-flop synchronisers for the asynchronous mic DOUT lines.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= mic_data_in;
      sync2 <= sync1;
    end
  end

  // Per-lane MSB-first deserialiser; a fresh word fully overwrites the
  // register after SAMPLE_BITS shifts, so no clear is needed between frames.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_reg <= '0;
    end else if (cap_en) begin
      shift_reg <= shift_nxt;
    end
  end

`ifdef I2S_RX_HANDSHAKE_EN
  // Held-valid output: a new word overwrites an unconsumed one and flags overrun,
  // unless the consumer takes the old word in the very same cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      overrun_out      <= 1'b0;
    end else if (deliver) begin
      sample_out       <= shift_nxt;
      sample_valid_out <= 1'b1;
      if (sample_valid_out && !ready_in) overrun_out <= 1'b1;
    end else if (sample_valid_out && ready_in) begin
      sample_valid_out <= 1'b0;
    end
  end
`else
  // Pulse output: load the completed word together with a 1-cycle valid.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= deliver;
      if (deliver) sample_out <= shift_nxt;
    end
  end

  assign overrun_out = 1'b0;

  logic unused_ready;
  assign unused_ready = ready_in;
`endif

endmodule

// File: tb/tb_i2s_mic_array_rx.sv
// tb_i2s_mic_array_rx: drives randomised mic words through behavioural I2S mic models.
// Expected BCLK/WS waveforms and word arrival times come from frame arithmetic.
// Build with +define+I2S_RX_HANDSHAKE_EN to exercise the held-valid/overrun variant.
module tb_i2s_mic_array_rx;
  localparam int NM    = 3;
  localparam int SB    = 24;
  localparam int DIV   = 32;
  localparam int SLOT  = 32;
  localparam int WF    = 2;
  localparam int FRAME = 2 * SLOT * DIV;            // 2048 clk per frame
  localparam int LAT   = SB * DIV + DIV / 2 + 2 + 1; // 787: capture of last bit + 1
  localparam int FIRST = WF * FRAME + LAT;          // first valid after enable

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              en_in = 1'b0;
  logic              ready_in = 1'b1;
  logic [NM-1:0]     mic_data_in = '0;
  logic              i2s_bclk_out;
  logic              i2s_ws_out;
  logic [NM*SB-1:0]  sample_out;
  logic              sample_valid_out;
  logic              overrun_out;

  int     checks = 0;
  int     errors = 0;
  longint fs_time = 0;
  int     last_t = 0;

  logic [SB-1:0] left_w  [NM];
  logic [SB-1:0] right_w [NM];

  i2s_mic_array_rx #(
    .NUM_MICS(NM), .BCLK_DIV(DIV), .SLOT_BITS(SLOT),
    .SAMPLE_BITS(SB), .WARMUP_FRAMES(WF)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in),
    .mic_data_in(mic_data_in), .i2s_bclk_out(i2s_bclk_out),
    .i2s_ws_out(i2s_ws_out), .sample_out(sample_out),
    .sample_valid_out(sample_valid_out), .ready_in(ready_in),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Mic model: counts BCLK falls since the last WS change and drives bit
  // (SB - pos) of its slot word for pos 1..SB; other positions carry junk.
  int   pos = 0;
  logic last_ws = 1'b0;
  always @(negedge i2s_bclk_out or posedge rst_in) begin
    if (rst_in) begin
      pos = 0;
      last_ws = 1'b0;
    end else begin
      #1;
      if (i2s_ws_out != last_ws) begin
        pos = 0;
        last_ws = i2s_ws_out;
      end else begin
        pos = pos + 1;
      end
      for (int k = 0; k < NM; k++) begin
        if (pos >= 1 && pos <= SB)
          mic_data_in[k] = last_ws ? right_w[k][SB-pos] : left_w[k][SB-pos];
        else
          mic_data_in[k] = 1'($urandom_range(0, 1));
      end
    end
  end

  function automatic int tnow();
    return int'(($time - fs_time) / 10);
  endfunction

  function automatic logic [NM*SB-1:0] exp_word();
    logic [NM*SB-1:0] r;
    r = '0;
    for (int k = 0; k < NM; k++) r[k*SB +: SB] = left_w[k];
    return r;
  endfunction

  task automatic set_words_random();
    for (int k = 0; k < NM; k++) begin
      left_w[k]  = SB'($urandom) | SB'(1);
      right_w[k] = SB'($urandom);
    end
  endtask

  task automatic start_run();
    @(negedge clk_in);
    en_in = 1'b1;
    fs_time = $time + 10;
  endtask

  task automatic wait_valid(input int budget, output bit got, output int t);
    got = 1'b0;
    t = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_in);
      if (sample_valid_out) begin
        got = 1'b1;
        t = tnow();
      end
    end
  endtask

  task automatic wait_phase(input int ph, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_in);
      if (tnow() % FRAME == ph) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++; if (i2s_bclk_out !== 1'b0) begin errors++; $display("FAIL reset_bclk got %b want 0", i2s_bclk_out); end
    checks++; if (i2s_ws_out !== 1'b0) begin errors++; $display("FAIL reset_ws got %b want 0", i2s_ws_out); end
    checks++; if (sample_out !== '0) begin errors++; $display("FAIL reset_sample got %h want 0", sample_out); end
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun_out); end
    rst_in = 1'b0;
    begin
      int busy = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk_in);
        if (i2s_bclk_out || i2s_ws_out || sample_valid_out) busy++;
      end
      checks++; if (busy != 0) begin errors++; $display("FAIL idle_quiet active_cycles %0d want 0", busy); end
    end
  endtask

  task automatic test_clocks();
    int   bad_b = 0, bad_w = 0, bad_edge = 0, rises = 0, ws_tog = 0, vld = 0;
    logic prev_b = 1'b0, prev_w = 1'b0;
    left_w[0] = 24'h800001; left_w[1] = 24'h7FFFFF; left_w[2] = 24'h123456;
    for (int k = 0; k < NM; k++) right_w[k] = SB'($urandom);
    start_run();
    for (int i = 0; i < 2200; i++) begin
      int t;
      @(negedge clk_in);
      t = tnow();
      if (i2s_bclk_out !== ((t % DIV) >= DIV / 2)) bad_b++;
      if (i2s_ws_out !== ((t % FRAME) >= FRAME / 2)) bad_w++;
      if (i2s_ws_out !== prev_w) begin
        ws_tog++;
        if (!(prev_b && !i2s_bclk_out)) bad_edge++;
      end
      if (!prev_b && i2s_bclk_out) rises++;
      if (sample_valid_out) vld++;
      prev_b = i2s_bclk_out;
      prev_w = i2s_ws_out;
    end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL bclk_wave bad_cycles %0d want 0", bad_b); end
    checks++; if (bad_w != 0) begin errors++; $display("FAIL ws_wave bad_cycles %0d want 0", bad_w); end
    checks++; if (bad_edge != 0) begin errors++; $display("FAIL ws_on_bclk_fall bad %0d want 0", bad_edge); end
    checks++; if (rises != (2200 - DIV / 2 + DIV - 1) / DIV) begin errors++; $display("FAIL bclk_rises got %0d want %0d", rises, (2200 - DIV / 2 + DIV - 1) / DIV); end
    checks++; if (ws_tog != 2) begin errors++; $display("FAIL ws_toggles got %0d want 2", ws_tog); end
    checks++; if (vld != 0) begin errors++; $display("FAIL warmup_valid got %0d want 0", vld); end
  endtask

  task automatic test_first_valid();
    bit got; int t;
    wait_valid(4096, got, t);
    checks++; if (!got || t != FIRST) begin errors++; $display("FAIL first_valid_time got %0d want %0d", t, FIRST); end
    checks++; if (sample_out !== 72'h123456_7FFFFF_800001) begin errors++; $display("FAIL first_sample got %h want 1234567fffff800001", sample_out); end
    last_t = t;
    @(negedge clk_in);
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b want 0", sample_valid_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL overrun_idle got %b want 0", overrun_out); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      bit got; int t;
      set_words_random();
      wait_valid(FRAME + 16, got, t);
      checks++; if (!got || t != last_t + FRAME) begin errors++; $display("FAIL rand_time[%0d] got %0d want %0d", f, t, last_t + FRAME); end
      checks++; if (sample_out !== exp_word()) begin errors++; $display("FAIL rand_sample[%0d] got %h want %h", f, sample_out, exp_word()); end
      last_t = t;
    end
  endtask

  task automatic test_right_slot();
    bit got; int t;
    for (int k = 0; k < NM; k++) begin left_w[k] = '0; right_w[k] = '1; end
    wait_valid(FRAME + 16, got, t);
    checks++; if (!got || t != last_t + FRAME) begin errors++; $display("FAIL right_time got %0d want %0d", t, last_t + FRAME); end
    checks++; if (sample_out !== '0) begin errors++; $display("FAIL right_ignored got %h want 0", sample_out); end
    last_t = t;
  endtask

  task automatic test_disable();
    bit got, ok; int t, fr, busy;
    set_words_random();
    wait_phase(10 * DIV + 8, FRAME + 16, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dis_phase_wait timed out want bit 10"); end
    fr = tnow() / FRAME;
    en_in = 1'b0;
    wait_valid(FRAME, got, t);
    checks++; if (!got || t != fr * FRAME + LAT) begin errors++; $display("FAIL dis_last_valid got %0d want %0d", t, fr * FRAME + LAT); end
    checks++; if (sample_out !== exp_word()) begin errors++; $display("FAIL dis_last_sample got %h want %h", sample_out, exp_word()); end
    wait_phase(FRAME - 1, FRAME + 16, ok);
    checks++; if (!ok || i2s_bclk_out !== 1'b1 || i2s_ws_out !== 1'b1) begin errors++; $display("FAIL dis_frame_tail bclk %b ws %b want 1 1", i2s_bclk_out, i2s_ws_out); end
    busy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (i2s_bclk_out || i2s_ws_out || sample_valid_out) busy++;
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL dis_idle active_cycles %0d want 0", busy); end
    set_words_random();
    start_run();
    wait_valid(FIRST + 16, got, t);
    checks++; if (!got || t != FIRST) begin errors++; $display("FAIL reen_valid_time got %0d want %0d", t, FIRST); end
    checks++; if (sample_out !== exp_word()) begin errors++; $display("FAIL reen_sample got %h want %h", sample_out, exp_word()); end
    last_t = t;
  endtask

  task automatic test_reset_mid();
    bit got, ok; int t, busy;
    wait_phase(12 * DIV + 5, FRAME + 16, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_phase_wait timed out want bit 12"); end
    rst_in = 1'b1;
    en_in = 1'b0;
    #1;
    checks++; if ({i2s_bclk_out, i2s_ws_out, sample_valid_out, overrun_out} !== 4'b0) begin errors++; $display("FAIL rst_mid_ctrl got %b want 0000", {i2s_bclk_out, i2s_ws_out, sample_valid_out, overrun_out}); end
    checks++; if (sample_out !== '0) begin errors++; $display("FAIL rst_mid_sample got %h want 0", sample_out); end
    @(negedge clk_in);
    rst_in = 1'b0;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (i2s_bclk_out || sample_valid_out) busy++;
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL rst_idle active_cycles %0d want 0", busy); end
    set_words_random();
    start_run();
    wait_valid(FIRST + 16, got, t);
    checks++; if (!got || t != FIRST) begin errors++; $display("FAIL rst_reen_time got %0d want %0d", t, FIRST); end
    checks++; if (sample_out !== exp_word()) begin errors++; $display("FAIL rst_reen_sample got %h want %h", sample_out, exp_word()); end
    last_t = t;
    @(negedge clk_in);
  endtask

`ifdef I2S_RX_HANDSHAKE_EN
  task automatic test_handshake();
    bit got; int t, low;
    logic [NM*SB-1:0] w;
    ready_in = 1'b0;
    set_words_random();
    wait_valid(FRAME + 16, got, t);
    checks++; if (!got || t != last_t + FRAME) begin errors++; $display("FAIL hs_first_time got %0d want %0d", t, last_t + FRAME); end
    checks++; if (sample_out !== exp_word()) begin errors++; $display("FAIL hs_first_sample got %h want %h", sample_out, exp_word()); end
    set_words_random();
    low = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      @(negedge clk_in);
      if (!sample_valid_out) low++;
    end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL hs_no_overrun_yet got %b want 0", overrun_out); end
    @(negedge clk_in);
    checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL hs_overrun got %b want 1", overrun_out); end
    checks++; if (sample_out !== exp_word()) begin errors++; $display("FAIL hs_overwrite got %h want %h", sample_out, exp_word()); end
    set_words_random();
    w = exp_word();
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk_in);
      if (!sample_valid_out) low++;
    end
    checks++; if (low != 0) begin errors++; $display("FAIL hs_valid_held low_cycles %0d want 0", low); end
    checks++; if (sample_out !== w) begin errors++; $display("FAIL hs_latest got %h want %h", sample_out, w); end
    ready_in = 1'b1;
    @(negedge clk_in);
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL hs_drop got %b want 0", sample_valid_out); end
    checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL hs_sticky got %b want 1", overrun_out); end
  endtask
`else
  task automatic test_ready_ignored();
    bit got; int t;
    ready_in = 1'b0;
    set_words_random();
    wait_valid(FRAME + 16, got, t);
    checks++; if (!got || t != last_t + FRAME) begin errors++; $display("FAIL noready_time got %0d want %0d", t, last_t + FRAME); end
    checks++; if (sample_out !== exp_word()) begin errors++; $display("FAIL noready_sample got %h want %h", sample_out, exp_word()); end
    @(negedge clk_in);
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL noready_pulse got %b want 0", sample_valid_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL noready_overrun got %b want 0", overrun_out); end
    ready_in = 1'b1;
  endtask
`endif

  initial begin
    for (int k = 0; k < NM; k++) begin left_w[k] = '0; right_w[k] = '0; end
    test_reset();
    test_clocks();
    test_first_valid();
    test_random_frames();
    test_right_slot();
    test_disable();
    test_reset_mid();
`ifdef I2S_RX_HANDSHAKE_EN
    test_handshake();
`else
    test_ready_ignored();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
